// File: rtl/min_sum_serial_tracker.sv
// Serial check-node tracker for layered min-sum LDPC decoding: exact min1/min2,
// argmin index, sign parity and row degree, one registered result per row.
module min_sum_serial_tracker #(
  parameter int unsigned MAG_W   = 5,
  parameter int unsigned MAX_DEG = 19,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned OFFSET  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_min1,
  output logic [MAG_W-1:0] out_min2,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_sign,
  output logic [IDX_W-1:0] out_deg,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  logic [MAG_W-1:0] min1, min2;
  logic [IDX_W-1:0] idx, cnt;
  logic             sign;

  logic [MAG_W-1:0] n_min1, n_min2;
  logic [IDX_W-1:0] n_idx, n_cnt;
  logic             n_sign;
  logic             accept, forced, term;

  function automatic logic [MAG_W-1:0] sat_off(input logic [MAG_W-1:0] m);
    if (32'(m) > OFFSET) return m - MAG_W'(OFFSET);
    else                 return '0;
  endfunction

  assign accept = in_valid & in_ready;

  // Running values after absorbing the current beat; the first beat of a row seeds them.
  always_comb begin
    n_min1 = min1;
    n_min2 = min2;
    n_idx  = idx;
    n_sign = sign ^ in_sign;
    n_cnt  = cnt + 1'b1;
    if (state == IDLE) begin
      n_min1 = in_mag;
      n_min2 = '1;
      n_idx  = '0;
      n_sign = in_sign;
      n_cnt  = IDX_W'(1);
    end else if (in_mag < min1) begin
      n_min2 = min1;
      n_min1 = in_mag;
      n_idx  = cnt;
    end else if (in_mag < min2) begin
      n_min2 = in_mag;
    end
    forced = (n_cnt == IDX_W'(MAX_DEG)) & ~in_last;
    term   = in_last | forced;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      min1      <= '0;
      min2      <= '0;
      idx       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_min1  <= '0;
      out_min2  <= '0;
      out_idx   <= '0;
      out_sign  <= 1'b0;
      out_deg   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            min1 <= n_min1;
            min2 <= n_min2;
            idx  <= n_idx;
            sign <= n_sign;
            cnt  <= n_cnt;
            if (term) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_min1  <= sat_off(n_min1);
              out_min2  <= sat_off(n_min2);
              out_idx   <= n_idx;
              out_sign  <= n_sign;
              out_deg   <= n_cnt;
              out_err   <= forced;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
